// File: rtl/stv_response_router.sv
// Response return path for a shared downstream port: records the granted
// requester of each issued request in order and steers responses back to it.
module stv_response_router #(
  parameter int OUTPUTS    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [OUTPUTS-1:0]           issue_gnt,
  input  logic                         issue_fire,
  output logic                         issue_ready,
  input  logic                         rsp_valid,
  output logic                         rsp_ready,
  input  logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [OUTPUTS-1:0]           out_valid,
  input  logic [OUTPUTS-1:0]           out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err
);

  localparam int IDXW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [IDXW-1:0] mem_q [DEPTH];
  logic [IDXW-1:0] mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic [IDXW-1:0] head;
  logic            nonempty;
  logic            sel_ready;
  logic            push;
  logic            pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest set grant bit wins if the vector is not one-hot.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = OUTPUTS - 1; i >= 0; i--) begin
      if (issue_gnt[i]) begin
        gnt_idx = IDXW'(i);
        gnt_any = 1'b1;
      end
    end
  end

  assign issue_ready = (count_q < CNTW'(DEPTH));
  assign nonempty    = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign out_data    = rsp_data;
  assign outstanding = count_q;
  assign err         = err_q;

  // When empty, responses are swallowed (rsp_ready high) and flagged.
  always_comb begin
    out_valid = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (head == IDXW'(i)) begin
        sel_ready    = out_ready[i];
        out_valid[i] = nonempty && rsp_valid;
      end
    end
    rsp_ready = nonempty ? sel_ready : 1'b1;
  end

  assign push = issue_fire && issue_ready && gnt_any;
  assign pop  = nonempty && rsp_valid && sel_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = (issue_fire && (!issue_ready || !gnt_any)) || (!nonempty && rsp_valid);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule
